// File: rtl/maj_fold_pkg.sv
// Shared types and sizing helpers for the folded majority/threshold evaluator.
// Optional build macro used by maj_fold_seq: MAJ_FOLD_EARLY_TERM_EN.
package maj_fold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-wide slices needed to cover n bits.
  function automatic int nch_f(input int n, input int chunk);
    return (n + chunk - 1) / chunk;
  endfunction

  // Width of the running ones count (holds 0..n).
  function automatic int cnt_w_f(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of out_cycles (holds 0..NCH).
  function automatic int cyc_w_f(input int n, input int chunk);
    return $clog2(nch_f(n, chunk) + 1);
  endfunction

  // Width of the chunk index (holds 0..NCH-1), never narrower than one bit.
  function automatic int idx_w_f(input int n, input int chunk);
    return (nch_f(n, chunk) <= 1) ? 1 : $clog2(nch_f(n, chunk));
  endfunction

endpackage

// File: rtl/maj_chunk_popcount.sv
// Combinational ones counter for a single CHUNK-bit slice of the operand.
module maj_chunk_popcount #(
  parameter int CHUNK = 7
) (
  input  logic [CHUNK-1:0]            bits,
  output logic [$clog2(CHUNK+1)-1:0]  count
);

  localparam int PCW = $clog2(CHUNK + 1);

  // Sum the bits of the slice.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + PCW'(bits[i]);
    end
  end

endmodule

// File: rtl/maj_fold_seq.sv
// Folded majority/threshold evaluator: y = (popcount(x) >= THRESH), CHUNK bits per cycle.
// Optional build macro: MAJ_FOLD_EARLY_TERM_EN -- finish as soon as the result is decided.
module maj_fold_seq
  import maj_fold_pkg::*;
#(
  parameter int N      = 21,
  parameter int CHUNK  = 7,
  parameter int THRESH = (N + 1) / 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N-1:0]                    in_x,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_y,
  output logic [cyc_w_f(N, CHUNK)-1:0]    out_cycles
);

  localparam int NCH = nch_f(N, CHUNK);
  localparam int CW  = cnt_w_f(N);
  localparam int YW  = cyc_w_f(N, CHUNK);
  localparam int IW  = idx_w_f(N, CHUNK);
  localparam int PW  = NCH * CHUNK;          // operand padded to whole chunks
  localparam int PCW = $clog2(CHUNK + 1);

  state_t          state_q;
  logic [PW-1:0]   op_q;
  logic [CW-1:0]   count_q;
  logic [IW-1:0]   idx_q;
  logic            out_valid_q;
  logic            out_y_q;
  logic [YW-1:0]   out_cycles_q;

  logic [CHUNK-1:0] chunk_bits;
  logic [PCW-1:0]   chunk_ones;
  logic [CW-1:0]    count_sum;
  logic             finish;
  logic             y_next;
  logic [YW-1:0]    cycles_next;

  // Select the current slice; padding bits above N-1 are zero in op_q.
  always_comb begin
    chunk_bits = op_q[int'(idx_q) * CHUNK +: CHUNK];
  end

  maj_chunk_popcount #(
    .CHUNK (CHUNK)
  ) u_popcount (
    .bits  (chunk_bits),
    .count (chunk_ones)
  );

  // Running count after this slice and the decision whether evaluation ends now.
  always_comb begin
    count_sum   = count_q + CW'(chunk_ones);
    y_next      = (int'(count_sum) >= THRESH);
`ifdef MAJ_FOLD_EARLY_TERM_EN
    begin
      int consumed;
      int rem;
      consumed    = (int'(idx_q) + 1) * CHUNK;
      rem         = (consumed >= N) ? 0 : (N - consumed);
      // Stop once reaching THRESH is certain or impossible.
      finish      = (int'(idx_q) == NCH - 1) ||
                    (int'(count_sum) >= THRESH) ||
                    (int'(count_sum) + rem < THRESH);
      cycles_next = YW'(int'(idx_q) + 1);
    end
`else
    finish      = (int'(idx_q) == NCH - 1);
    cycles_next = YW'(NCH);
`endif
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand register is reset too; it is small and a reset abort must leave no stale state behind.
      state_q      <= IDLE;
      op_q         <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_y_q      <= 1'b0;
      out_cycles_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= PW'(in_x);
            count_q <= '0;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          count_q <= count_sum;
          idx_q   <= idx_q + 1'b1;
          if (finish) begin
            out_y_q      <= y_next;
            out_cycles_q <= cycles_next;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_cycles = out_cycles_q;

endmodule

// File: tb/tb_maj_fold_seq.sv
// Directed + random scoreboard bench for maj_fold_seq (default N=21 instance and a small N=5 instance).
module tb_maj_fold_seq;

  localparam int N      = 21;
  localparam int CHUNK  = 7;
  localparam int THRESH = 11;
  localparam int NCH    = 3;
  localparam int YW     = 2;

  localparam int N2     = 5;
  localparam int CHUNK2 = 2;
  localparam int THR2   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_x = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_y;
  logic [YW-1:0] out_cycles;

  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [N2-1:0] s_in_x = '0;
  logic          s_out_valid;
  logic          s_out_ready = 1'b0;
  logic          s_out_y;
  logic [1:0]    s_out_cycles;

  typedef struct packed {
    logic          y;
    logic [YW-1:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  maj_fold_seq #(.N(N), .CHUNK(CHUNK), .THRESH(THRESH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_cycles (out_cycles)
  );

  maj_fold_seq #(.N(N2), .CHUNK(CHUNK2), .THRESH(THR2)) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_x       (s_in_x),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_y      (s_out_y),
    .out_cycles (s_out_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected RUN cycles for the default instance.
  function automatic int model_cycles(input logic [N-1:0] x);
`ifdef MAJ_FOLD_EARLY_TERM_EN
    int cnt;
    int rem;
    cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      for (int b = i * CHUNK; b < (i + 1) * CHUNK; b++) begin
        if (b < N) cnt += int'(x[b]);
      end
      rem = N - (i + 1) * CHUNK;
      if (rem < 0) rem = 0;
      if (cnt >= THRESH || cnt + rem < THRESH) return i + 1;
    end
    return NCH;
`else
    return NCH + 0 * int'(x[0]);
`endif
  endfunction

  // One full transaction on the default instance, with `hold` back-pressure cycles in DONE.
  task automatic run_op(input logic [N-1:0] x, input int hold);
    exp_t e;
    exp_t got;
    int   cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_x     = x;
    e.y      = ($countones(x) >= THRESH);
    e.cyc    = YW'(model_cycles(x));
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    in_x     = ~x;          // must not affect the in-flight operand
    check("in_ready_busy", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("latency", cyc, model_cycles(x));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_x     = ~x;
      tick();
      in_valid = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_y", out_y, e.y);
      check("hold_cycles", out_cycles, e.cyc);
    end
    out_ready = 1'b1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("out_y", out_y, got.y);
      check("out_cycles", out_cycles, got.cyc);
    end
    tick();
    out_ready = 1'b0;
    check("released_valid", out_valid, 0);
    check("released_in_ready", in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_cycles", out_cycles, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed patterns and boundaries
    run_op(21'h1FFFFF, 0);
    run_op(21'h000000, 0);
    run_op(21'h0007FF, 0);
    run_op(21'h0003FF, 0);
    run_op(21'h155555, 0);
    run_op(21'h1FFC00, 0);

    // Back-pressure with a rejected competing operand
    run_op(21'h0F0F0F, 5);
    run_op(21'h000001, 0);

    // Reset mid-RUN
    in_valid = 1'b1;
    in_x     = 21'h1FFFFF;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", out_valid, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_result", out_valid, 0);
    end
    run_op(21'h000000, 0);

    // Random vectors
    for (int i = 0; i < 150; i++) begin
      run_op(N'($urandom), 0);
    end

    // Small instance: N=5, CHUNK=2, THRESH=3, padded last chunk
    s_in_valid = 1'b1;
    s_in_x     = 5'b10101;
    tick();
    s_in_valid = 1'b0;
    cyc = 0;
    while (!s_out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("small_latency", cyc, 3);
    check("small_y", s_out_y, 1);
    check("small_cycles", s_out_cycles, 3);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    check("small_in_ready", s_in_ready, 1);
    s_in_valid = 1'b1;
    s_in_x     = 5'b00011;
    tick();
    s_in_valid = 1'b0;
    cyc = 0;
    while (!s_out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("small_valid2", s_out_valid, 1);
    check("small_y2", s_out_y, 0);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
